reg_scan_reader: RTL and testbench

Debug/observation reader for the 8-entry register file; the read-side counterpart to the datapath's write port.
- On a start pulse, walks a programmable address range on a dedicated read-port select (rf_addr).
- Captures each word from that port's combinational read data.
- Streams (address, data) pairs out over a valid/ready handshake to a display or UART formatter.
- Used to dump R0..R7 (R7 = LR) while the multi-cycle CPU runs or is halted.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/reg_scan_reader_if.sv | 26 ++
 rtl/reg_scan_reader_en_reg.sv | 15 +
 rtl/reg_scan_reader.sv | 87 ++++++++
 tb/tb_reg_scan_reader.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the register-file scan reader.
package cpu_pkg;
    localparam int W        = 8;
    localparam int AW       = 3;
    localparam int LR_INDEX = 7;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } scan_state_t;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return a + 1'b1;
    endfunction
endpackage

// File: rtl/reg_scan_reader_if.sv
// Valid/ready stream of (address, data, last) words from the scan reader.
interface reg_scan_reader_if;
    import cpu_pkg::*;

    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [W-1:0]  out_data;
    logic          out_last;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/reg_scan_reader_en_reg.sv
// Generic load-enable register with asynchronous active-high clear.
module en_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/reg_scan_reader.sv
// Walks a register-file address range on a dedicated read port and
// streams the captured (address, data) pairs over a valid/ready link.
module reg_scan_reader
    import cpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [AW-1:0]            lo_addr,
    input  logic [AW-1:0]            hi_addr,
    output logic [AW-1:0]            rf_addr,
    input  logic [W-1:0]             rf_data,
    reg_scan_reader_if.master        stream,
    output logic                     busy,
    output logic                     done
);
    localparam int CW = 1 + AW + W;

    scan_state_t   state_q, state_d;
    logic [AW-1:0] cur_q;
    logic [AW-1:0] hi_q;
    logic [AW-1:0] rf_addr_q;
    logic          hs;
    logic          cap_en;
    logic [CW-1:0] cap_d;
    logic [CW-1:0] cap_q;

    assign hs     = (state_q == SEND) && stream.out_ready;
    assign cap_en = (state_q == READ) && !abort;
    assign cap_d  = {cur_q == hi_q, cur_q, rf_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = READ;
            READ: state_d = SEND;
            SEND: begin
                if (hs) state_d = stream.out_last ? DONE : READ;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q <= '0;
            hi_q  <= '0;
        end else if (state_q == IDLE && start) begin
            cur_q <= lo_addr;
            hi_q  <= hi_addr;
        end else if (hs && !stream.out_last && !abort) begin
            cur_q <= next_addr(cur_q);
        end
    end

    // Read port select shows cur during READ and keeps its last value after.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 rf_addr_q <= '0;
        else if (state_q == READ)  rf_addr_q <= cur_q;
    end

    assign rf_addr = (state_q == READ) ? cur_q : rf_addr_q;

    en_reg #(.WIDTH(CW)) u_cap (
        .clk   (clk),
        .reset (reset),
        .en    (cap_en),
        .d     (cap_d),
        .q     (cap_q)
    );

    assign stream.out_last  = cap_q[CW-1];
    assign stream.out_addr  = cap_q[W +: AW];
    assign stream.out_data  = cap_q[W-1:0];
    assign stream.out_valid = (state_q == SEND);

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_reg_scan_reader.sv
// Directed cycle-accurate bench for reg_scan_reader.
module tb_reg_scan_reader;
    import cpu_pkg::*;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] lo_addr;
    logic [AW-1:0] hi_addr;
    logic [AW-1:0] rf_addr;
    logic [W-1:0]  rf_data;
    logic          busy;
    logic          done;
    logic [W-1:0]  rf [8];

    int n_checks = 0;
    int n_fail   = 0;

    reg_scan_reader_if sif ();

    reg_scan_reader dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .lo_addr (lo_addr),
        .hi_addr (hi_addr),
        .rf_addr (rf_addr),
        .rf_data (rf_data),
        .stream  (sif.master),
        .busy    (busy),
        .done    (done)
    );

    assign rf_data = rf[rf_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({sif.out_valid, sif.out_last, busy, done} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 0000",
                     {sif.out_valid, sif.out_last, busy, done});
        end
        n_checks++;
        if (rf_addr !== 3'd0 || sif.out_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_addr got rf=%0d out=%0d exp 0",
                     rf_addr, sif.out_addr);
        end
        n_checks++;
        if (sif.out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data got %h exp 00", sif.out_data);
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || sif.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset got busy=%b valid=%b exp 0",
                         busy, sif.out_valid);
            end
        end
    endtask

    // Cycle-exact scan with out_ready=1; optional stray start at restart_cyc.
    task automatic test_scan(input string name, input logic [2:0] lo,
                             input logic [2:0] hi, input int restart_cyc);
        int n;
        int k;
        int words;
        int dones;
        logic [2:0] ea;
        logic exp_valid;
        logic [2:0] d;
        d = hi - lo;
        n = int'(d) + 1;
        words = 0;
        dones = 0;
        @(negedge clk);
        lo_addr = lo;
        hi_addr = hi;
        sif.out_ready = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 2 * n + 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) begin
                lo_addr = lo + 3'd3;
                hi_addr = hi + 3'd2;
            end
            exp_valid = (c >= 2 && c <= 2 * n && c % 2 == 0);
            n_checks++;
            if (sif.out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL %s valid c=%0d got %b exp %b",
                         name, c, sif.out_valid, exp_valid);
            end
            if (exp_valid) begin
                k = c / 2 - 1;
                ea = lo + 3'(k);
                n_checks++;
                if (sif.out_addr !== ea || sif.out_data !== (8'h10 | {5'b0, ea})) begin
                    n_fail++;
                    $display("FAIL %s word c=%0d got a=%0d d=%h exp a=%0d d=%h",
                             name, c, sif.out_addr, sif.out_data,
                             ea, 8'h10 | {5'b0, ea});
                end
                n_checks++;
                if (sif.out_last !== (k == n - 1)) begin
                    n_fail++;
                    $display("FAIL %s last c=%0d got %b exp %b",
                             name, c, sif.out_last, k == n - 1);
                end
            end
            if (c % 2 == 1 && c < 2 * n) begin
                ea = lo + 3'((c - 1) / 2);
                n_checks++;
                if (rf_addr !== ea) begin
                    n_fail++;
                    $display("FAIL %s rf_addr c=%0d got %0d exp %0d",
                             name, c, rf_addr, ea);
                end
            end
            n_checks++;
            if (busy !== (c <= 2 * n + 1) || done !== (c == 2 * n + 1)) begin
                n_fail++;
                $display("FAIL %s busy_done c=%0d got %b%b exp %b%b",
                         name, c, busy, done, c <= 2 * n + 1, c == 2 * n + 1);
            end
            if (sif.out_valid && sif.out_ready) words++;
            if (done) dones++;
            if (c == restart_cyc) begin
                lo_addr = 3'd5;
                hi_addr = 3'd5;
                start = 1'b1;
            end
        end
        n_checks++;
        if (words != n || dones != 1) begin
            n_fail++;
            $display("FAIL %s totals got words=%0d dones=%0d exp %0d 1",
                     name, words, dones, n);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        lo_addr = 3'd2;
        hi_addr = 3'd3;
        sif.out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk);
            if (c == 3) rf[2] = 8'hAA;
            n_checks++;
            if (sif.out_valid !== 1'b1 || sif.out_addr !== 3'd2 ||
                sif.out_data !== 8'h12 || sif.out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold c=%0d got v=%b a=%0d d=%h l=%b exp 1 2 12 0",
                         c, sif.out_valid, sif.out_addr, sif.out_data, sif.out_last);
            end
        end
        sif.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (sif.out_valid !== 1'b0 || rf_addr !== 3'd3) begin
            n_fail++;
            $display("FAIL bp_read got v=%b rf=%0d exp 0 3", sif.out_valid, rf_addr);
        end
        @(negedge clk);
        n_checks++;
        if (sif.out_valid !== 1'b1 || sif.out_addr !== 3'd3 ||
            sif.out_data !== 8'h13 || sif.out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second got v=%b a=%0d d=%h l=%b exp 1 3 13 1",
                     sif.out_valid, sif.out_addr, sif.out_data, sif.out_last);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done got done=%b busy=%b exp 1 1", done, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle got done=%b busy=%b exp 0 0", done, busy);
        end
        rf[2] = 8'h12;
    endtask

    task automatic test_abort();
        @(negedge clk);
        lo_addr = 3'd0;
        hi_addr = 3'd7;
        sif.out_ready = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_checks++;
        if (sif.out_valid !== 1'b1 || sif.out_addr !== 3'd3) begin
            n_fail++;
            $display("FAIL abort_pre got v=%b a=%0d exp 1 3", sif.out_valid, sif.out_addr);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_next got v=%b busy=%b done=%b exp 000",
                     sif.out_valid, busy, done);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet c=%0d got v=%b busy=%b done=%b exp 000",
                         c, sif.out_valid, busy, done);
            end
        end
        test_scan("post_abort", 3'd0, 3'd7, 0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        lo_addr = 3'd0;
        hi_addr = 3'd7;
        sif.out_ready = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_checks++;
        if (rf_addr !== 3'd1 || sif.out_data !== 8'h10) begin
            n_fail++;
            $display("FAIL areset_pre got rf=%0d d=%h exp 1 10", rf_addr, sif.out_data);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({sif.out_valid, sif.out_last, busy, done} !== 4'b0 ||
            rf_addr !== 3'd0 || sif.out_addr !== 3'd0 || sif.out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_now got v=%b l=%b b=%b dn=%b rf=%0d a=%0d d=%h exp all 0",
                     sif.out_valid, sif.out_last, busy, done,
                     rf_addr, sif.out_addr, sif.out_data);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (sif.out_valid !== 1'b0 || busy !== 1'b0 || rf_addr !== 3'd0) begin
                n_fail++;
                $display("FAIL areset_quiet c=%0d got v=%b busy=%b rf=%0d exp 0 0 0",
                         c, sif.out_valid, busy, rf_addr);
            end
        end
        test_scan("post_reset", 3'd3, 3'd5, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        lo_addr = '0;
        hi_addr = '0;
        sif.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 8'h10 + 8'(i);

        test_reset();
        test_scan("full_dump", 3'd0, 3'd7, 0);
        test_scan("start_busy", 3'd0, 3'd7, 5);
        test_scan("wrap", 3'd6, 3'd1, 0);
        test_scan("single", 3'd4, 3'd4, 0);
        test_scan("lr_only", 3'(LR_INDEX), 3'(LR_INDEX), 0);
        test_backpressure();
        test_abort();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
